// File: rtl/blake2_io_pkg.sv
// Shared types and constants for the BLAKE2b byte-wide pin interface.
// Holds the serializer state encoding, field widths and the digest-length decode.
// No logic; imported by hash_out_serializer and hash_out_chk.
package blake2_io_pkg;

  localparam int NN_W         = 6;
  localparam int IDX_W        = 6;
  localparam int DIGEST_BYTES = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } hash_out_state_t;

  // nn==0 encodes a full 64-byte digest; any other value is the byte count.
  function automatic logic [IDX_W:0] nn_to_len(input logic [NN_W-1:0] nn);
    logic [IDX_W:0] len;
    if (nn == '0) begin
      len = (IDX_W+1)'(DIGEST_BYTES);
    end else begin
      len = {1'b0, nn};
    end
    return len;
  endfunction

endpackage

// File: rtl/hash_out_chk.sv
// XOR accumulator producing the trailing check byte of a digest frame.
// Latency: accumulated value visible one cycle after the last byte is folded in.
// No backpressure: folds every byte presented with acc_vld_i, cleared at frame start.
module hash_out_chk
  import blake2_io_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       clr_i,
  input  logic       acc_vld_i,
  input  logic [7:0] acc_dat_i,
  output logic [7:0] chk_dat_o
);

  logic [7:0] acc_q;
  logic [7:0] acc_d;

  // Clear on frame start, otherwise fold each digest byte as it reaches the output stage.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_vld_i) begin
      acc_d = acc_q ^ acc_dat_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign chk_dat_o = acc_q;

endmodule

// File: rtl/hash_out_serializer.sv
// Streams the final BLAKE2b digest to the hash_o pins, one byte per cycle (optional check byte: HASH_OUT_CHK_EN).
// Latency: res_v_i in cycle 0 -> read strobe cycle 1 -> byte 0 on hash_o in cycle 3, gap-free thereafter.
// No backpressure on the pins; new res_v_i is dropped while busy_o, and ready_v_o is masked for the frame.
module hash_out_serializer
  import blake2_io_pkg::*;
(
  input  logic             clk,
  input  logic             nreset,
  input  logic             en_i,
  input  logic [NN_W-1:0]  nn_i,
  input  logic             res_v_i,
  input  logic             ready_v_i,
  input  logic [7:0]       byte_i,
  output logic             byte_rd_o,
  output logic [IDX_W-1:0] byte_idx_o,
  output logic             busy_o,
  output logic             ready_v_o,
  output logic             hash_v_o,
  output logic [7:0]       hash_o,
  output logic             hash_last_o
);

  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

  hash_out_state_t  state_q, state_d;
  logic             en_q, en_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [IDX_W:0]   rd_cnt_q, rd_cnt_d;
  logic             byte_rd_q, byte_rd_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic             rd_last_q, rd_last_d;
  logic             p1_vld_q, p1_vld_d;
  logic             p1_last_q, p1_last_d;
  logic             busy_q, busy_d;
  logic             hash_v_q, hash_v_d;
  logic [7:0]       hash_q, hash_d;
  logic             hash_last_q, hash_last_d;
  logic             accept;
  logic [IDX_W:0]   new_len;

  assign accept  = (state_q == IDLE) && res_v_i && en_q;
  assign new_len = nn_to_len(nn_i);

`ifdef HASH_OUT_CHK_EN
  logic       dig_last_q, dig_last_d;
  logic [7:0] chk_dat;

  hash_out_chk u_chk (
    .clk       (clk),
    .nreset    (nreset),
    .clr_i     (accept),
    .acc_vld_i (p1_vld_q),
    .acc_dat_i (byte_i),
    .chk_dat_o (chk_dat)
  );
`endif

  // Frame control: accept a digest, issue one read per cycle, then wait for the last byte to leave.
  always_comb begin
    state_d    = state_q;
    en_d       = en_i;
    len_d      = len_q;
    rd_cnt_d   = rd_cnt_q;
    byte_rd_d  = 1'b0;
    byte_idx_d = byte_idx_q;
    rd_last_d  = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          len_d      = new_len;
          rd_cnt_d   = CNT_ONE;
          byte_rd_d  = 1'b1;
          byte_idx_d = '0;
          rd_last_d  = (new_len == CNT_ONE);
          busy_d     = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        // rd_cnt counts reads already issued; one spare bit lets len=64 stop without wrapping.
        if (rd_cnt_q < len_q) begin
          byte_rd_d  = 1'b1;
          byte_idx_d = rd_cnt_q[IDX_W-1:0];
          rd_last_d  = (rd_cnt_q == (len_q - CNT_ONE));
          rd_cnt_d   = rd_cnt_q + CNT_ONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hash_last_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Read pipeline: the strobe is delayed one stage to line up with byte_i, then byte_i is registered onto the pins.
  always_comb begin
    p1_vld_d  = byte_rd_q;
    p1_last_d = rd_last_q;
`ifdef HASH_OUT_CHK_EN
    dig_last_d  = p1_vld_q & p1_last_q;
    hash_v_d    = p1_vld_q | dig_last_q;
    hash_last_d = dig_last_q;
    if (p1_vld_q) begin
      hash_d = byte_i;
    end else if (dig_last_q) begin
      hash_d = chk_dat;
    end else begin
      hash_d = hash_q;
    end
`else
    hash_v_d    = p1_vld_q;
    hash_last_d = p1_vld_q & p1_last_q;
    hash_d      = p1_vld_q ? byte_i : hash_q;
`endif
  end

  // State, pipeline and registered output flops.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      len_q       <= '0;
      rd_cnt_q    <= '0;
      byte_rd_q   <= 1'b0;
      byte_idx_q  <= '0;
      rd_last_q   <= 1'b0;
      p1_vld_q    <= 1'b0;
      p1_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      hash_v_q    <= 1'b0;
      hash_q      <= '0;
      hash_last_q <= 1'b0;
`ifdef HASH_OUT_CHK_EN
      dig_last_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      len_q       <= len_d;
      rd_cnt_q    <= rd_cnt_d;
      byte_rd_q   <= byte_rd_d;
      byte_idx_q  <= byte_idx_d;
      rd_last_q   <= rd_last_d;
      p1_vld_q    <= p1_vld_d;
      p1_last_q   <= p1_last_d;
      busy_q      <= busy_d;
      hash_v_q    <= hash_v_d;
      hash_q      <= hash_d;
      hash_last_q <= hash_last_d;
`ifdef HASH_OUT_CHK_EN
      dig_last_q  <= dig_last_d;
`endif
    end
  end

  assign byte_rd_o   = byte_rd_q;
  assign byte_idx_o  = byte_idx_q;
  assign busy_o      = busy_q;
  assign ready_v_o   = ready_v_i & ~busy_q;
  assign hash_v_o    = hash_v_q;
  assign hash_o      = hash_q;
  assign hash_last_o = hash_last_q;

endmodule

// File: tb/tb_hash_out_serializer.sv
// Bench for hash_out_serializer: directed frame scenarios with randomized digest contents and ready_v_i.
// Expected pin timeline is derived per cycle from frame length and a byte array holding the core's digest.
// Define HASH_OUT_CHK_EN for both bench and RTL to exercise the trailing check byte.
`timescale 1ns/1ps
module tb_hash_out_serializer;
  import blake2_io_pkg::*;

  logic             clk = 1'b0;
  logic             nreset;
  logic             en_i;
  logic [NN_W-1:0]  nn_i;
  logic             res_v_i;
  logic             ready_v_i;
  logic [7:0]       byte_i;
  logic             byte_rd_o;
  logic [IDX_W-1:0] byte_idx_o;
  logic             busy_o;
  logic             ready_v_o;
  logic             hash_v_o;
  logic [7:0]       hash_o;
  logic             hash_last_o;

  hash_out_serializer dut (
    .clk         (clk),
    .nreset      (nreset),
    .en_i        (en_i),
    .nn_i        (nn_i),
    .res_v_i     (res_v_i),
    .ready_v_i   (ready_v_i),
    .byte_i      (byte_i),
    .byte_rd_o   (byte_rd_o),
    .byte_idx_o  (byte_idx_o),
    .busy_o      (busy_o),
    .ready_v_o   (ready_v_o),
    .hash_v_o    (hash_v_o),
    .hash_o      (hash_o),
    .hash_last_o (hash_last_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  logic [7:0] mem [64];
  logic [7:0] last_hash = 8'h00;
  logic [7:0] pend = 8'h00;
  logic       pend_v = 1'b0;

  // Core digest port: a strobe seen in cycle k presents mem[idx] on byte_i during cycle k+1; garbage otherwise.
  always @(negedge clk) begin
    if (pend_v) byte_i = pend;
    else        byte_i = 8'($urandom);
    pend_v = byte_rd_o;
    pend   = mem[byte_idx_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_byte_rd"},   32'(byte_rd_o),   32'd0);
    chk({tag, "_byte_idx"},  32'(byte_idx_o),  32'd0);
    chk({tag, "_busy"},      32'(busy_o),      32'd0);
    chk({tag, "_hash_v"},    32'(hash_v_o),    32'd0);
    chk({tag, "_hash"},      32'(hash_o),      32'd0);
    chk({tag, "_hash_last"}, 32'(hash_last_o), 32'd0);
  endtask

  task automatic idle_watch(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle_busy",    32'(busy_o),    32'd0);
      chk("idle_hash_v",  32'(hash_v_o),  32'd0);
      chk("idle_byte_rd", 32'(byte_rd_o), 32'd0);
      chk("idle_hash",    32'(hash_o),    32'(last_hash));
      chk("idle_ready_v", 32'(ready_v_o), 32'(ready_v_i));
      ready_v_i = 1'($urandom);
    end
  endtask

  // Called at a negedge; that cycle is cycle 0 with res_v_i high.
  task automatic run_frame(input logic [NN_W-1:0] nn, input int repulse_cyc,
                           input int endrop_cyc, input int abort_cyc);
    int         len;
    int         flen;
    logic [7:0] x;
    logic       er, eb, ev, el;
    len  = (nn == '0) ? 64 : int'(nn);
    flen = len;
`ifdef HASH_OUT_CHK_EN
    flen = len + 1;
`endif
    x = 8'h00;
    for (int j = 0; j < len; j++) x = x ^ mem[j];
    nn_i    = nn;
    res_v_i = 1'b1;
    for (int c = 1; c <= flen + 4; c++) begin
      @(negedge clk);
      er = (c >= 1) && (c <= len);
      eb = (c >= 1) && (c <= 2 + flen);
      ev = (c >= 3) && (c <= 2 + flen);
      el = (c == 2 + flen);
      if (ev) last_hash = (c - 3 < len) ? mem[c-3] : x;
      chk("byte_rd", 32'(byte_rd_o), 32'(er));
      if (er) chk("byte_idx", 32'(byte_idx_o), 32'(c - 1));
      chk("busy",      32'(busy_o),      32'(eb));
      chk("hash_v",    32'(hash_v_o),    32'(ev));
      chk("hash_last", 32'(hash_last_o), 32'(el));
      chk("hash",      32'(hash_o),      32'(last_hash));
      chk("ready_v",   32'(ready_v_o),   32'(ready_v_i & ~eb));
      if (c == abort_cyc) begin
        nreset = 1'b0;
        #1;
        chk_zero_outputs("abort");
        last_hash = 8'h00;
        res_v_i   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        idle_watch(8);
        return;
      end
      res_v_i = (c == repulse_cyc);
      if (c == endrop_cyc) en_i = 1'b0;
      ready_v_i = 1'($urandom);
    end
    res_v_i = 1'b0;
    en_i    = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    nreset    = 1'b0;
    en_i      = 1'b1;
    nn_i      = '0;
    res_v_i   = 1'b0;
    ready_v_i = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // 32-byte frame, core returns its own index.
    run_frame(6'd32, -1, -1, -1);

    // nn=0 -> full 64-byte digest, random contents.
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    run_frame(6'd0, -1, -1, -1);

    // Single-byte frame.
    mem[0] = 8'($urandom);
    run_frame(6'd1, -1, -1, -1);

    // res_v_i re-pulsed while byte 5 is on the pins: no restart.
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    run_frame(6'd16, 8, -1, -1);
    idle_watch(4);

    // en_i dropped mid-frame: frame completes unchanged.
    run_frame(6'd12, -1, 5, -1);

    // res_v_i with enable low: no frame.
    en_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    res_v_i = 1'b1;
    @(negedge clk);
    res_v_i = 1'b0;
    idle_watch(6);
    en_i = 1'b1;
    @(negedge clk);

    // Reset while byte 10 of 32 is on the pins.
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    run_frame(6'd32, -1, -1, 13);
    en_i = 1'b1;
    @(negedge clk);

    // Short frame with one-hot bytes; with the check byte enabled the frame ends on 0x0F.
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
    run_frame(6'd4, -1, -1, -1);

    // Random lengths and contents.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      run_frame(NN_W'($urandom_range(0, 63)), -1, -1, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
